// File: rtl/uart_hex_pkg.sv
// Shared types and the character classifier for the UART hex parser.
package uart_hex_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned WORD_W   = 16;

    localparam logic [BYTE_W-1:0] ASC_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] ASC_LF = 8'h0A;
    localparam logic [BYTE_W-1:0] ASC_SP = 8'h20;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } ack_state_t;

    typedef enum logic [1:0] {
        CC_DIGIT = 2'd0,
        CC_SEP   = 2'd1,
        CC_BAD   = 2'd2
    } char_class_t;

    // HI: next digit is the high nibble; LO: a high nibble is pending.
    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } digit_phase_t;

    typedef struct packed {
        char_class_t           cls;
        logic [NIBBLE_W-1:0]   nib;
    } char_decode_t;

    // Classify one ASCII character and return its nibble value when it is a hex digit.
    function automatic char_decode_t classify_char(input logic [BYTE_W-1:0] c,
                                                   input logic              accept_lower);
        char_decode_t r;
        r.cls = CC_BAD;
        r.nib = '0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.cls = CC_DIGIT;
            r.nib = c[3:0];
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r.cls = CC_DIGIT;
            r.nib = c[3:0] + 4'd9;
        end else if (accept_lower && c >= 8'h61 && c <= 8'h66) begin
            r.cls = CC_DIGIT;
            r.nib = c[3:0] + 4'd9;
        end else if (c == ASC_CR || c == ASC_LF || c == ASC_SP) begin
            r.cls = CC_SEP;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_hex_parser_decode.sv
// Combinational ASCII hex character classifier, reusable by the board top.
module hex_char_decode
    import uart_hex_pkg::*;
#(
    parameter logic ACCEPT_LOWER = 1'b1
) (
    input  logic [7:0] char_i,
    output logic [1:0] cls_o,
    output logic [3:0] nibble_o
);

    char_decode_t dec_c;

    // Pure lookup of the character class and nibble value.
    always_comb begin
        dec_c = classify_char(char_i, ACCEPT_LOWER);
    end

    assign cls_o    = dec_c.cls;
    assign nibble_o = dec_c.nib;

endmodule

// File: rtl/uart_hex_parser.sv
// UART receive-side hex pair decoder: handshakes characters, assembles bytes,
// keeps the last two bytes for the display and raises sticky error flags.
module uart_hex_parser
    import uart_hex_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter logic        ACCEPT_LOWER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_ready_clr,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [15:0] disp_word,
    input  logic        err_clr,
    output logic        err_bad_char,
    output logic        err_odd,
    output logic        err_ack_timeout
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    ack_state_t           state_q;
    digit_phase_t         phase_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NIBBLE_W-1:0]  hi_q;
    logic                 stall_q;
    logic                 rx_ready_clr_q;
    logic [BYTE_W-1:0]    byte_data_q;
    logic                 byte_valid_q;
    logic [WORD_W-1:0]    disp_word_q;
    logic                 err_bad_char_q;
    logic                 err_odd_q;
    logic                 err_ack_timeout_q;

    logic                 err_bad_char_d;
    logic                 err_odd_d;
    logic                 err_ack_timeout_d;

    logic [1:0]           cls_c;
    logic [NIBBLE_W-1:0]  nib_c;
    logic [BYTE_W-1:0]    byte_c;
    logic                 accept_c;
    logic                 is_digit_c;
    logic                 is_sep_c;
    logic                 bad_set_c;
    logic                 odd_set_c;
    logic                 to_set_c;

    hex_char_decode #(
        .ACCEPT_LOWER (ACCEPT_LOWER)
    ) u_decode (
        .char_i   (rx_data),
        .cls_o    (cls_c),
        .nibble_o (nib_c)
    );

    // Accept and error-event qualification for the current cycle.
    always_comb begin
        accept_c   = (state_q == S_IDLE) && rx_ready && !stall_q;
        is_digit_c = (cls_c == CC_DIGIT);
        is_sep_c   = (cls_c == CC_SEP);
        byte_c     = {hi_q, nib_c};
        bad_set_c  = accept_c && !is_digit_c && !is_sep_c;
        odd_set_c  = accept_c && is_sep_c && (phase_q == PH_LO);
        to_set_c   = (state_q == S_WAIT) && rx_ready && (cnt_q == CNT_MAX);
    end

    // Sticky flags: clear request first, a coincident new event wins.
    always_comb begin
        err_bad_char_d    = (err_bad_char_q    && !err_clr) || bad_set_c;
        err_odd_d         = (err_odd_q         && !err_clr) || odd_set_c;
        err_ack_timeout_d = (err_ack_timeout_q && !err_clr) || to_set_c;
    end

    // Acknowledge FSM, digit phase, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            phase_q           <= PH_HI;
            cnt_q             <= '0;
            hi_q              <= '0;
            stall_q           <= 1'b0;
            rx_ready_clr_q    <= 1'b0;
            byte_data_q       <= '0;
            byte_valid_q      <= 1'b0;
            disp_word_q       <= '0;
            err_bad_char_q    <= 1'b0;
            err_odd_q         <= 1'b0;
            err_ack_timeout_q <= 1'b0;
        end else begin
            rx_ready_clr_q    <= 1'b0;
            byte_valid_q      <= 1'b0;
            err_bad_char_q    <= err_bad_char_d;
            err_odd_q         <= err_odd_d;
            err_ack_timeout_q <= err_ack_timeout_d;

            // A character abandoned by timeout is ignored until the line drops.
            if (!rx_ready) begin
                stall_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        rx_ready_clr_q <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= S_WAIT;
                        if (is_digit_c) begin
                            if (phase_q == PH_HI) begin
                                hi_q    <= nib_c;
                                phase_q <= PH_LO;
                            end else begin
                                byte_data_q  <= byte_c;
                                byte_valid_q <= 1'b1;
                                disp_word_q  <= {disp_word_q[7:0], byte_c};
                                phase_q      <= PH_HI;
                            end
                        end else begin
                            phase_q <= PH_HI;
                        end
                    end
                end
                S_WAIT: begin
                    if (!rx_ready) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        stall_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready_clr    = rx_ready_clr_q;
    assign byte_data       = byte_data_q;
    assign byte_valid      = byte_valid_q;
    assign disp_word       = disp_word_q;
    assign err_bad_char    = err_bad_char_q;
    assign err_odd         = err_odd_q;
    assign err_ack_timeout = err_ack_timeout_q;

endmodule

// File: tb/tb_uart_hex_parser.sv
// Bench for uart_hex_parser: two instances (lowercase accepted / rejected)
// share one stimulus stream and are compared against a character-level model.
module tb_uart_hex_parser;

    localparam int TO = 64;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       err_clr;

    logic        clr_w [2];
    logic [7:0]  bd_w  [2];
    logic        bv_w  [2];
    logic [15:0] dw_w  [2];
    logic        eb_w  [2];
    logic        eo_w  [2];
    logic        et_w  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = lowercase accepted, 1 = lowercase rejected.
    bit          m_pend  [2];
    logic [3:0]  m_hi    [2];
    logic [7:0]  m_byte  [2];
    logic [15:0] m_disp  [2];
    bit          m_valid [2];
    bit          m_bad   [2];
    bit          m_odd   [2];
    bit          m_to    [2];
    bit          s_valid [2];
    bit          s_clr   [2];

    uart_hex_parser #(.ACK_TIMEOUT(TO), .ACCEPT_LOWER(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_ready_clr(clr_w[0]), .byte_data(bd_w[0]), .byte_valid(bv_w[0]),
        .disp_word(dw_w[0]), .err_clr(err_clr), .err_bad_char(eb_w[0]),
        .err_odd(eo_w[0]), .err_ack_timeout(et_w[0])
    );

    uart_hex_parser #(.ACK_TIMEOUT(TO), .ACCEPT_LOWER(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_ready_clr(clr_w[1]), .byte_data(bd_w[1]), .byte_valid(bv_w[1]),
        .disp_word(dw_w[1]), .err_clr(err_clr), .err_bad_char(eb_w[1]),
        .err_odd(eo_w[1]), .err_ack_timeout(et_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic string tag(input int d);
        return (d == 0) ? "A" : "B";
    endfunction

    // Hex value of a character, or -1 when it is not a digit.
    function automatic int nib_of(input logic [7:0] c, input bit al);
        string up = "0123456789ABCDEF";
        string lo = "0123456789abcdef";
        for (int i = 0; i < 16; i++) begin
            if (c == up[i] || (al && c == lo[i])) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_hi[d] = '0; m_byte[d] = '0; m_disp[d] = '0;
            m_valid[d] = 0; m_bad[d] = 0; m_odd[d] = 0; m_to[d] = 0;
        end
    endtask

    task automatic model_clr_only();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_bad[d] = 0; m_odd[d] = 0; m_to[d] = 0;
        end
    endtask

    task automatic model_char(input int d, input logic [7:0] c, input bit clr);
        int n;
        n = nib_of(c, d == 0);
        m_valid[d] = 0;
        if (clr) begin
            m_bad[d] = 0; m_odd[d] = 0; m_to[d] = 0;
        end
        if (n >= 0) begin
            if (!m_pend[d]) begin
                m_hi[d]   = 4'(n);
                m_pend[d] = 1;
            end else begin
                m_byte[d]  = {m_hi[d], 4'(n)};
                m_disp[d]  = {m_disp[d][7:0], m_byte[d]};
                m_valid[d] = 1;
                m_pend[d]  = 0;
            end
        end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
            if (m_pend[d]) m_odd[d] = 1;
            m_pend[d] = 0;
        end else begin
            m_bad[d]  = 1;
            m_pend[d] = 0;
        end
    endtask

    task automatic check_model(input int d, input string where);
        chk({where, ".", tag(d), ".byte_valid"}, 32'(bv_w[d]), 32'(m_valid[d]));
        chk({where, ".", tag(d), ".byte_data"},  32'(bd_w[d]), 32'(m_byte[d]));
        chk({where, ".", tag(d), ".disp_word"},  32'(dw_w[d]), 32'(m_disp[d]));
        chk({where, ".", tag(d), ".err_bad"},    32'(eb_w[d]), 32'(m_bad[d]));
        chk({where, ".", tag(d), ".err_odd"},    32'(eo_w[d]), 32'(m_odd[d]));
        chk({where, ".", tag(d), ".err_to"},     32'(et_w[d]), 32'(m_to[d]));
    endtask

    // One full uart handshake: present, expect ack next cycle, drop, idle.
    task automatic send_char(input logic [7:0] c, input bit clr, input string where);
        @(negedge clk);
        rx_data  = c;
        rx_ready = 1'b1;
        err_clr  = clr;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_char(d, c, clr);
            s_valid[d] = bv_w[d];
            chk({where, ".", tag(d), ".ack"}, 32'(clr_w[d]), 32'd1);
            check_model(d, where);
        end
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({where, ".", tag(d), ".ack_end"},   32'(clr_w[d]), 32'd0);
            chk({where, ".", tag(d), ".valid_end"}, 32'(bv_w[d]),  32'd0);
        end
    endtask

    task automatic pulse_clr(input string where);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_clr_only();
        for (int d = 0; d < 2; d++) check_model(d, where);
    endtask

    typedef struct {
        bit         is_clr;
        logic [7:0] c;
        bit         valid;
        logic [7:0] bdat;
        logic [15:0] disp;
        bit         bad;
        bit         odd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n_ack [2];
        int n_bv  [2];
        int to_at [2];
        string pool;
        logic [7:0] c;
        int r;

        tbl[0]  = '{0, "3",   0, 8'h00, 16'h0000, 0, 0};
        tbl[1]  = '{0, "F",   1, 8'h3F, 16'h003F, 0, 0};
        tbl[2]  = '{0, "a",   0, 8'h3F, 16'h003F, 0, 0};
        tbl[3]  = '{0, "7",   1, 8'hA7, 16'h3FA7, 0, 0};
        tbl[4]  = '{0, 8'h0D, 0, 8'hA7, 16'h3FA7, 0, 0};
        tbl[5]  = '{0, "5",   0, 8'hA7, 16'h3FA7, 0, 0};
        tbl[6]  = '{0, 8'h0A, 0, 8'hA7, 16'h3FA7, 0, 1};
        tbl[7]  = '{0, "1",   0, 8'hA7, 16'h3FA7, 0, 1};
        tbl[8]  = '{0, "2",   1, 8'h12, 16'hA712, 0, 1};
        tbl[9]  = '{1, 8'h00, 0, 8'h12, 16'hA712, 0, 0};
        tbl[10] = '{0, "4",   0, 8'h12, 16'hA712, 0, 0};
        tbl[11] = '{0, "G",   0, 8'h12, 16'hA712, 1, 0};
        tbl[12] = '{0, "2",   0, 8'h12, 16'hA712, 1, 0};
        tbl[13] = '{0, "0",   1, 8'h20, 16'h1220, 1, 0};
        tbl[14] = '{1, 8'h00, 0, 8'h20, 16'h1220, 0, 0};

        rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({"reset.", tag(d), ".ack"}, 32'(clr_w[d]), 32'd0);
            check_model(d, "reset");
        end

        // Directed table against instance A, model for both.
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_clr) begin
                pulse_clr($sformatf("tbl%0d", i));
                s_valid[0] = bv_w[0];
            end else begin
                send_char(tbl[i].c, 1'b0, $sformatf("tbl%0d", i));
            end
            chk($sformatf("tbl%0d.valid", i), 32'(s_valid[0]), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d.byte", i),  32'(bd_w[0]),    32'(tbl[i].bdat));
            chk($sformatf("tbl%0d.disp", i),  32'(dw_w[0]),    32'(tbl[i].disp));
            chk($sformatf("tbl%0d.bad", i),   32'(eb_w[0]),    32'(tbl[i].bad));
            chk($sformatf("tbl%0d.odd", i),   32'(eo_w[0]),    32'(tbl[i].odd));
        end

        // Clear and new error in the same cycle: the new error wins.
        send_char("5", 1'b0, "pre_setwin");
        send_char(8'h20, 1'b0, "odd_setwin");
        send_char("Z", 1'b1, "setwin");
        chk("setwin.A.bad_kept", 32'(eb_w[0]), 32'd1);
        chk("setwin.A.odd_cleared", 32'(eo_w[0]), 32'd0);
        pulse_clr("setwin_clr");

        // Stuck rx_ready: one ack, timeout flag, no second decode.
        @(negedge clk);
        rx_data = "A"; rx_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_ack[d] = 0; n_bv[d] = 0; to_at[d] = 0;
        end
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (clr_w[d]) n_ack[d]++;
                if (bv_w[d])  n_bv[d]++;
                if (et_w[d] && to_at[d] == 0) to_at[d] = k;
            end
        end
        rx_ready = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_char(d, "A", 1'b0);
            m_to[d] = 1;
            chk({"stuck.", tag(d), ".acks"},   32'(n_ack[d]), 32'd1);
            chk({"stuck.", tag(d), ".valids"}, 32'(n_bv[d]),  32'd0);
            chk({"stuck.", tag(d), ".to_cycle"}, 32'(to_at[d]), 32'(TO + 1));
            check_model(d, "stuck");
        end
        send_char("5", 1'b0, "after_stuck");
        chk("after_stuck.A.byte", 32'(bd_w[0]), 32'h0000_00A5);
        pulse_clr("stuck_clr");

        // Reset with a pending nibble and a character offered during reset.
        send_char("B", 1'b0, "pre_rst");
        @(negedge clk);
        rst = 1'b1; rx_data = "7"; rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk({"in_rst.", tag(d), ".ack"}, 32'(clr_w[d]), 32'd0);
        rx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_model(d, "post_rst");
        send_char("C", 1'b0, "rst_c");
        send_char("D", 1'b0, "rst_d");
        chk("rst_cd.A.byte", 32'(bd_w[0]), 32'h0000_00CD);
        chk("rst_cd.A.disp", 32'(dw_w[0]), 32'h0000_00CD);

        // Randomized characters, separators, bad bytes and clear pulses.
        pool = "0123456789ABCDEFabcdef GZx!";
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      c = 8'h0D;
            else if (r == 1) c = 8'h0A;
            else             c = pool[int'($urandom_range(0, pool.len() - 1))];
            send_char(c, ($urandom_range(0, 9) == 0), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
